// File: rtl/store_buffer_ctrl_if.sv
// rtl/store_buffer_ctrl_if.sv - pipeline/memory-side signal bundle of the store buffer
interface store_buffer_ctrl_if #(
   parameter int SB_SIZE = 4
);
   localparam int IW = (SB_SIZE > 1) ? $clog2(SB_SIZE) : 1;

   logic          alloc_valid_i;
   logic [31:0]   alloc_addr_i;
   logic [31:0]   alloc_data_i;
   logic [1:0]    alloc_size_i;
   logic          alloc_ready_o;
   logic [IW-1:0] alloc_idx_o;
   logic          commit_valid_i;
   logic [IW-1:0] commit_idx_i;
   logic          flush_i;
   logic          mem_req_valid_o;
   logic [31:0]   mem_req_addr_o;
   logic [31:0]   mem_req_data_o;
   logic [1:0]    mem_req_size_o;
   logic          mem_req_ready_i;
   logic          ld_valid_i;
   logic [31:0]   ld_addr_i;
   logic          ld_hit_o;
   logic [31:0]   ld_data_o;
   logic          ld_stall_o;
   logic          empty_o;
   logic          full_o;

   modport master (
      output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i,
      output commit_valid_i, commit_idx_i, flush_i, mem_req_ready_i,
      output ld_valid_i, ld_addr_i,
      input  alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o,
      input  mem_req_data_o, mem_req_size_o, ld_hit_o, ld_data_o, ld_stall_o,
      input  empty_o, full_o
   );

   modport slave (
      input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_size_i,
      input  commit_valid_i, commit_idx_i, flush_i, mem_req_ready_i,
      input  ld_valid_i, ld_addr_i,
      output alloc_ready_o, alloc_idx_o, mem_req_valid_o, mem_req_addr_o,
      output mem_req_data_o, mem_req_size_o, ld_hit_o, ld_data_o, ld_stall_o,
      output empty_o, full_o
   );
endinterface

// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - in-order store buffer with commit, flush, drain and load forwarding
module store_buffer_ctrl #(
   parameter int SB_SIZE = 4
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   store_buffer_ctrl_if.slave  sb
);
   localparam int IW = (SB_SIZE > 1) ? $clog2(SB_SIZE) : 1;
   localparam int CW = $clog2(SB_SIZE + 1);

   typedef logic [IW-1:0] store_buffer_idx_t;
   typedef logic [31:0]   bus32_t;
   typedef enum logic [1:0] {ST_FREE, ST_PENDING, ST_COMMITTED} ent_st_t;

   ent_st_t           st_q [SB_SIZE];
   ent_st_t           st_d [SB_SIZE];
   bus32_t            addr_q [SB_SIZE];
   bus32_t            data_q [SB_SIZE];
   logic [1:0]        size_q [SB_SIZE];
   store_buffer_idx_t head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   logic              alloc_acc, commit_ok, drain, oldest_found;
   store_buffer_idx_t oldest_idx, scan_idx, fwd_idx;
   logic [CW-1:0]     n_cmt;
   logic              fwd_found;

   function automatic store_buffer_idx_t wrap_add(input store_buffer_idx_t base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= SB_SIZE) s = s - SB_SIZE;
      return store_buffer_idx_t'(s);
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < SB_SIZE; i++) st_q[i] <= ST_FREE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < SB_SIZE; i++) st_q[i] <= st_d[i];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (alloc_acc) begin
            addr_q[tail_q] <= sb.alloc_addr_i;
            data_q[tail_q] <= sb.alloc_data_i;
            size_q[tail_q] <= sb.alloc_size_i;
         end
      end
   end

   always_comb begin
      oldest_found = 1'b0;
      oldest_idx   = head_q;
      scan_idx     = head_q;
      n_cmt        = '0;
      // Pending entries sit contiguously after the committed ones, so the first one from head is the oldest.
      for (int k = 0; k < SB_SIZE; k++) begin
         scan_idx = wrap_add(head_q, k);
         if (k < int'(count_q) && st_q[scan_idx] == ST_PENDING && !oldest_found) begin
            oldest_found = 1'b1;
            oldest_idx   = scan_idx;
         end
      end
      for (int i = 0; i < SB_SIZE; i++)
         if (st_q[i] == ST_COMMITTED) n_cmt = n_cmt + CW'(1);

      commit_ok = sb.commit_valid_i && oldest_found && (sb.commit_idx_i == oldest_idx);
      drain     = (st_q[head_q] == ST_COMMITTED) && sb.mem_req_ready_i;
      alloc_acc = sb.alloc_valid_i && (count_q != CW'(SB_SIZE)) && !sb.flush_i;

      for (int i = 0; i < SB_SIZE; i++) begin
         st_d[i] = st_q[i];
         if (commit_ok && store_buffer_idx_t'(i) == sb.commit_idx_i) st_d[i] = ST_COMMITTED;
         if (sb.flush_i && st_d[i] == ST_PENDING) st_d[i] = ST_FREE;
         if (drain && store_buffer_idx_t'(i) == head_q) st_d[i] = ST_FREE;
         if (alloc_acc && store_buffer_idx_t'(i) == tail_q) st_d[i] = ST_PENDING;
      end

      head_d = drain ? wrap_add(head_q, 1) : head_q;
      if (sb.flush_i) begin
         // Survivors are exactly the committed run starting at head, including a same-cycle commit.
         n_cmt   = n_cmt + CW'(commit_ok);
         tail_d  = wrap_add(head_q, int'(n_cmt));
         count_d = n_cmt - CW'(drain);
      end else begin
         tail_d  = alloc_acc ? wrap_add(tail_q, 1) : tail_q;
         count_d = count_q + CW'(alloc_acc) - CW'(drain);
      end
   end

   always_comb begin
      sb.alloc_ready_o   = (count_q != CW'(SB_SIZE));
      sb.alloc_idx_o     = tail_q;
      sb.empty_o         = (count_q == '0);
      sb.full_o          = (count_q == CW'(SB_SIZE));
      sb.mem_req_valid_o = (st_q[head_q] == ST_COMMITTED);
      sb.mem_req_addr_o  = addr_q[head_q];
      sb.mem_req_data_o  = data_q[head_q];
      sb.mem_req_size_o  = size_q[head_q];

      fwd_found = 1'b0;
      fwd_idx   = head_q;
      // Walk oldest to youngest so the last match wins.
      for (int k = 0; k < SB_SIZE; k++) begin
         if (k < int'(count_q) && st_q[wrap_add(head_q, k)] != ST_FREE &&
             addr_q[wrap_add(head_q, k)][31:2] == sb.ld_addr_i[31:2]) begin
            fwd_found = 1'b1;
            fwd_idx   = wrap_add(head_q, k);
         end
      end

      sb.ld_hit_o   = 1'b0;
      sb.ld_data_o  = '0;
      sb.ld_stall_o = 1'b0;
      if (sb.ld_valid_i && fwd_found) begin
         if (size_q[fwd_idx] == 2'd2) begin
            sb.ld_hit_o  = 1'b1;
            sb.ld_data_o = data_q[fwd_idx];
         end else begin
            sb.ld_stall_o = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb/tb_store_buffer_ctrl.sv - directed self-checking bench for store_buffer_ctrl
module tb_store_buffer_ctrl;
   logic clk_i = 1'b0;
   logic rstn_i;
   int   checks   = 0;
   int   failures = 0;

   store_buffer_ctrl_if #(.SB_SIZE(4)) sb ();

   store_buffer_ctrl #(.SB_SIZE(4)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .sb     (sb)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
   endtask

   task automatic do_alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      sb.alloc_valid_i = 1'b1;
      sb.alloc_addr_i  = a;
      sb.alloc_data_i  = d;
      sb.alloc_size_i  = s;
      tick();
      sb.alloc_valid_i = 1'b0;
   endtask

   task automatic do_commit(input logic [1:0] idx);
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = idx;
      tick();
      sb.commit_valid_i = 1'b0;
   endtask

   initial begin
      rstn_i            = 1'b0;
      sb.alloc_valid_i  = 1'b0;
      sb.alloc_addr_i   = '0;
      sb.alloc_data_i   = '0;
      sb.alloc_size_i   = '0;
      sb.commit_valid_i = 1'b0;
      sb.commit_idx_i   = '0;
      sb.flush_i        = 1'b0;
      sb.mem_req_ready_i = 1'b0;
      sb.ld_valid_i     = 1'b0;
      sb.ld_addr_i      = '0;
      tick();
      tick();
      rstn_i = 1'b1;

      chk("rst_empty", 32'(sb.empty_o), 1);
      chk("rst_full", 32'(sb.full_o), 0);
      chk("rst_ready", 32'(sb.alloc_ready_o), 1);
      chk("rst_idx", 32'(sb.alloc_idx_o), 0);
      chk("rst_memv", 32'(sb.mem_req_valid_o), 0);

      // Fill without commit, then a fifth request
      for (int i = 0; i < 4; i++) begin
         sb.alloc_valid_i = 1'b1;
         sb.alloc_addr_i  = 32'h300 + 32'(4 * i);
         sb.alloc_data_i  = 32'(i);
         sb.alloc_size_i  = 2'd2;
         #1;
         chk($sformatf("fill_idx%0d", i), 32'(sb.alloc_idx_o), 32'(i));
         tick();
      end
      chk("fill_full", 32'(sb.full_o), 1);
      chk("fill_ready", 32'(sb.alloc_ready_o), 0);
      sb.alloc_addr_i = 32'h3F0;
      tick();
      sb.alloc_valid_i = 1'b0;
      chk("fifth_full", 32'(sb.full_o), 1);
      chk("fifth_idx", 32'(sb.alloc_idx_o), 0);
      sb.ld_valid_i = 1'b1;
      sb.ld_addr_i  = 32'h3F0;
      #1;
      chk("fifth_not_stored", 32'(sb.ld_hit_o), 0);
      sb.ld_valid_i = 1'b0;
      sb.flush_i = 1'b1;
      tick();
      sb.flush_i = 1'b0;
      chk("flush_all_pending_empty", 32'(sb.empty_o), 1);

      // Drain with back-pressure
      do_reset();
      do_alloc(32'h100, 32'hDEADBEEF, 2'd2);
      chk("drain_no_req_before_commit", 32'(sb.mem_req_valid_o), 0);
      do_commit(2'd0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("hold_valid%0d", c), 32'(sb.mem_req_valid_o), 1);
         chk($sformatf("hold_addr%0d", c), sb.mem_req_addr_o, 32'h100);
         chk($sformatf("hold_data%0d", c), sb.mem_req_data_o, 32'hDEADBEEF);
         tick();
      end
      chk("hold_size", 32'(sb.mem_req_size_o), 2);
      sb.mem_req_ready_i = 1'b1;
      tick();
      sb.mem_req_ready_i = 1'b0;
      chk("drain_empty", 32'(sb.empty_o), 1);
      chk("drain_valid_low", 32'(sb.mem_req_valid_o), 0);

      // Commit then flush: younger pending stores dropped, committed one drains
      do_reset();
      do_alloc(32'h400, 32'hA, 2'd2);
      do_alloc(32'h404, 32'hB, 2'd2);
      do_alloc(32'h408, 32'hC, 2'd2);
      do_commit(2'd1);
      chk("ooo_commit_ignored", 32'(sb.mem_req_valid_o), 0);
      do_commit(2'd0);
      sb.flush_i = 1'b1;
      tick();
      sb.flush_i = 1'b0;
      chk("flush_next_idx", 32'(sb.alloc_idx_o), 1);
      chk("flush_A_valid", 32'(sb.mem_req_valid_o), 1);
      chk("flush_A_addr", sb.mem_req_addr_o, 32'h400);
      sb.ld_valid_i = 1'b1;
      sb.ld_addr_i  = 32'h404;
      #1;
      chk("flush_B_gone", 32'(sb.ld_hit_o), 0);
      sb.ld_valid_i = 1'b0;
      sb.mem_req_ready_i = 1'b1;
      tick();
      sb.mem_req_ready_i = 1'b0;
      chk("flush_A_drained", 32'(sb.empty_o), 1);

      // Same-cycle commit + flush + alloc
      do_reset();
      do_alloc(32'h600, 32'h66, 2'd2);
      sb.commit_valid_i = 1'b1;
      sb.commit_idx_i   = 2'd0;
      sb.flush_i        = 1'b1;
      sb.alloc_valid_i  = 1'b1;
      sb.alloc_addr_i   = 32'h604;
      tick();
      sb.commit_valid_i = 1'b0;
      sb.flush_i        = 1'b0;
      sb.alloc_valid_i  = 1'b0;
      chk("cf_commit_survives", 32'(sb.mem_req_valid_o), 1);
      chk("cf_alloc_dropped", 32'(sb.alloc_idx_o), 1);

      // Forwarding
      do_reset();
      do_alloc(32'h200, 32'h11, 2'd2);
      do_alloc(32'h200, 32'h22, 2'd2);
      sb.ld_valid_i = 1'b1;
      sb.ld_addr_i  = 32'h200;
      #1;
      chk("fwd_hit", 32'(sb.ld_hit_o), 1);
      chk("fwd_youngest", sb.ld_data_o, 32'h22);
      chk("fwd_nostall", 32'(sb.ld_stall_o), 0);
      sb.ld_addr_i = 32'h202;
      #1;
      chk("fwd_word_align", sb.ld_data_o, 32'h22);
      do_alloc(32'h204, 32'h55, 2'd0);
      sb.ld_addr_i = 32'h204;
      #1;
      chk("fwd_byte_stall", 32'(sb.ld_stall_o), 1);
      chk("fwd_byte_nohit", 32'(sb.ld_hit_o), 0);
      sb.ld_addr_i = 32'h208;
      #1;
      chk("fwd_miss", {sb.ld_data_o[29:0], sb.ld_hit_o, sb.ld_stall_o}, 0);
      sb.alloc_valid_i = 1'b1;
      sb.alloc_addr_i  = 32'h20C;
      sb.alloc_data_i  = 32'h77;
      sb.alloc_size_i  = 2'd2;
      sb.ld_addr_i     = 32'h20C;
      #1;
      chk("fwd_sameclk_invisible", 32'(sb.ld_hit_o), 0);
      tick();
      sb.alloc_valid_i = 1'b0;
      chk("fwd_after_alloc", sb.ld_data_o, 32'h77);
      sb.ld_valid_i = 1'b0;
      #1;
      chk("fwd_ld_invalid", 32'(sb.ld_hit_o), 0);

      // Full buffer: drain and alloc same cycle, then wrap
      do_reset();
      for (int i = 0; i < 4; i++) do_alloc(32'h500 + 32'(4 * i), 32'(i), 2'd2);
      do_commit(2'd0);
      sb.mem_req_ready_i = 1'b1;
      sb.alloc_valid_i   = 1'b1;
      sb.alloc_addr_i    = 32'h510;
      #1;
      chk("full_drain_ready", 32'(sb.alloc_ready_o), 0);
      tick();
      sb.mem_req_ready_i = 1'b0;
      chk("freed_ready", 32'(sb.alloc_ready_o), 1);
      chk("wrap_idx", 32'(sb.alloc_idx_o), 0);
      tick();
      sb.alloc_valid_i = 1'b0;
      chk("wrap_full", 32'(sb.full_o), 1);
      do_commit(2'd1);
      sb.mem_req_ready_i = 1'b1;
      tick();
      sb.mem_req_ready_i = 1'b0;
      do_commit(2'd2);
      sb.mem_req_ready_i = 1'b1;
      sb.alloc_valid_i   = 1'b1;
      sb.alloc_addr_i    = 32'h514;
      tick();
      sb.mem_req_ready_i = 1'b0;
      sb.alloc_valid_i   = 1'b0;
      chk("drain_alloc_count_full", 32'(sb.full_o), 0);
      chk("drain_alloc_idx", 32'(sb.alloc_idx_o), 2);
      chk("drain_alloc_head", sb.mem_req_addr_o, 32'h50C);

      // Reset during an outstanding request
      do_commit(2'd3);
      chk("pre_rst_valid", 32'(sb.mem_req_valid_o), 1);
      rstn_i = 1'b0;
      tick();
      chk("rst_req_dropped", 32'(sb.mem_req_valid_o), 0);
      chk("rst2_empty", 32'(sb.empty_o), 1);
      chk("rst2_full", 32'(sb.full_o), 0);
      chk("rst2_idx", 32'(sb.alloc_idx_o), 0);
      rstn_i = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
